butterfly_pipe: RTL and testbench

- Parametrised, fully pipelined radix-2 butterfly for the FFT datapath. Computes c = a + w·b and d = a − w·b on signed fixed-point complex operands.
- Successor to the single-shot iterative butterfly. Accepts one transaction per cycle instead of blocking on an iterative multiplier.
- Adds two per-transaction mode bits: twiddle bypass (w = 1) and 1/2 output scaling.
- Uses a valid/ready handshake on both sides, so it chains directly between FFT stages.

---
 rtl/butterfly_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: fully pipelined radix-2 FFT butterfly, c = a + w*b and d = a - w*b, valid/ready on both sides.
// Define BUTTERFLY_PIPE_SAT_EN to saturate every N-bit reduction and report it on ovf; by default results wrap and ovf is 0.
`timescale 1ns/1ps
module butterfly_pipe #(
    parameter int N      = 32,
    parameter int D      = 16,
    parameter int STAGES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                recv_val,
    output logic                recv_rdy,
    input  logic signed [N-1:0] ar,
    input  logic signed [N-1:0] ac,
    input  logic signed [N-1:0] br,
    input  logic signed [N-1:0] bc,
    input  logic signed [N-1:0] wr,
    input  logic signed [N-1:0] wc,
    input  logic                bypass,
    input  logic                scale,
    output logic                send_val,
    input  logic                send_rdy,
    output logic signed [N-1:0] cr,
    output logic signed [N-1:0] cc,
    output logic signed [N-1:0] dr,
    output logic signed [N-1:0] dc,
    output logic                ovf
);

    typedef struct packed {
        logic         o;
        logic [N-1:0] v;
    } red_t;

    function automatic red_t reduce_mul(input logic signed [2*N:0] x);
        red_t r;
        r.o = 1'b0;
        r.v = x[N-1:0];
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (x[2*N:N-1] != {(N+2){x[N-1]}}) begin
            r.o = 1'b1;
            r.v = x[2*N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        return r;
    endfunction

    function automatic red_t reduce_sum(input logic signed [N:0] x);
        red_t r;
        r.o = 1'b0;
        r.v = x[N-1:0];
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (x[N] != x[N-1]) begin
            r.o = 1'b1;
            r.v = x[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
        return r;
    endfunction

    // The whole pipe freezes while the output beat is refused.
    logic adv;
    assign adv      = !(send_val && !send_rdy);
    assign recv_rdy = !send_val || send_rdy;

    // Stage p0: operand capture
    logic                vld_p0;
    logic                bypass_p0, scale_p0;
    logic signed [N-1:0] ar_p0, ac_p0, br_p0, bc_p0, wr_p0, wc_p0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= recv_val;
        end
    end

    always_ff @(posedge clk) begin
        if (adv && recv_val) begin
            ar_p0     <= ar;
            ac_p0     <= ac;
            br_p0     <= br;
            bc_p0     <= bc;
            wr_p0     <= wr;
            wc_p0     <= wc;
            bypass_p0 <= bypass;
            scale_p0  <= scale;
        end
    end

    // Complex multiply on the p0 operands; exact 2N+1-bit accumulate, then floor shift by D.
    logic signed [2*N-1:0] p_rr, p_cc, p_rc, p_cr;
    logic signed [2*N:0]   acc_r, acc_c;
    red_t                  m_r, m_c;
    logic signed [N-1:0]   tr_c, tc_c;
    logic                  tovf_c;

    always_comb begin
        p_rr   = (2*N)'(br_p0) * (2*N)'(wr_p0);
        p_cc   = (2*N)'(bc_p0) * (2*N)'(wc_p0);
        p_rc   = (2*N)'(br_p0) * (2*N)'(wc_p0);
        p_cr   = (2*N)'(bc_p0) * (2*N)'(wr_p0);
        acc_r  = {p_rr[2*N-1], p_rr} - {p_cc[2*N-1], p_cc};
        acc_c  = {p_rc[2*N-1], p_rc} + {p_cr[2*N-1], p_cr};
        m_r    = reduce_mul(acc_r >>> D);
        m_c    = reduce_mul(acc_c >>> D);
        tr_c   = bypass_p0 ? br_p0 : $signed(m_r.v);
        tc_c   = bypass_p0 ? bc_p0 : $signed(m_c.v);
        tovf_c = !bypass_p0 && (m_r.o || m_c.o);
    end

    logic                vld_f, scale_f, tovf_f;
    logic signed [N-1:0] ar_f, ac_f, tr_f, tc_f;

    generate
        if (STAGES == 2) begin : g_direct
            assign vld_f   = vld_p0;
            assign scale_f = scale_p0;
            assign tovf_f  = tovf_c;
            assign ar_f    = ar_p0;
            assign ac_f    = ac_p0;
            assign tr_f    = tr_c;
            assign tc_f    = tc_c;
        end else begin : g_chain
            localparam int M = STAGES - 2;
            // Stage p1: product registers, followed by plain delay slots when STAGES > 3
            logic                vld_p1   [M];
            logic                scale_p1 [M];
            logic                tovf_p1  [M];
            logic signed [N-1:0] ar_p1    [M];
            logic signed [N-1:0] ac_p1    [M];
            logic signed [N-1:0] tr_p1    [M];
            logic signed [N-1:0] tc_p1    [M];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int k = 0; k < M; k++) vld_p1[k] <= 1'b0;
                end else if (adv) begin
                    vld_p1[0] <= vld_p0;
                    for (int k = 1; k < M; k++) vld_p1[k] <= vld_p1[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    scale_p1[0] <= scale_p0;
                    tovf_p1[0]  <= tovf_c;
                    ar_p1[0]    <= ar_p0;
                    ac_p1[0]    <= ac_p0;
                    tr_p1[0]    <= tr_c;
                    tc_p1[0]    <= tc_c;
                    for (int k = 1; k < M; k++) begin
                        scale_p1[k] <= scale_p1[k-1];
                        tovf_p1[k]  <= tovf_p1[k-1];
                        ar_p1[k]    <= ar_p1[k-1];
                        ac_p1[k]    <= ac_p1[k-1];
                        tr_p1[k]    <= tr_p1[k-1];
                        tc_p1[k]    <= tc_p1[k-1];
                    end
                end
            end

            assign vld_f   = vld_p1[M-1];
            assign scale_f = scale_p1[M-1];
            assign tovf_f  = tovf_p1[M-1];
            assign ar_f    = ar_p1[M-1];
            assign ac_f    = ac_p1[M-1];
            assign tr_f    = tr_p1[M-1];
            assign tc_f    = tc_p1[M-1];
        end
    endgenerate

    // a +/- t in N+1 bits; scaling halves the wide value, which always fits in N bits.
    logic signed [N:0]   s_cr, s_cc, s_dr, s_dc;
    red_t                r_cr, r_cc, r_dr, r_dc;
    logic signed [N-1:0] cr_n, cc_n, dr_n, dc_n;
    logic                ovf_n;

    always_comb begin
        s_cr = {ar_f[N-1], ar_f} + {tr_f[N-1], tr_f};
        s_cc = {ac_f[N-1], ac_f} + {tc_f[N-1], tc_f};
        s_dr = {ar_f[N-1], ar_f} - {tr_f[N-1], tr_f};
        s_dc = {ac_f[N-1], ac_f} - {tc_f[N-1], tc_f};
        r_cr = reduce_sum(s_cr);
        r_cc = reduce_sum(s_cc);
        r_dr = reduce_sum(s_dr);
        r_dc = reduce_sum(s_dc);
        if (scale_f) begin
            cr_n  = s_cr[N:1];
            cc_n  = s_cc[N:1];
            dr_n  = s_dr[N:1];
            dc_n  = s_dc[N:1];
            ovf_n = tovf_f;
        end else begin
            cr_n  = $signed(r_cr.v);
            cc_n  = $signed(r_cc.v);
            dr_n  = $signed(r_dr.v);
            dc_n  = $signed(r_dc.v);
            ovf_n = tovf_f || r_cr.o || r_cc.o || r_dr.o || r_dc.o;
        end
    end

    // Output stage: data only updates on a valid beat, so bubbles leave the last result visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            send_val <= 1'b0;
            cr       <= '0;
            cc       <= '0;
            dr       <= '0;
            dc       <= '0;
            ovf      <= 1'b0;
        end else if (adv) begin
            send_val <= vld_f;
            if (vld_f) begin
                cr  <= cr_n;
                cc  <= cc_n;
                dr  <= dr_n;
                dc  <= dc_n;
                ovf <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed cases plus randomized traffic against a wide-integer reference model.
`timescale 1ns/1ps
module tb_butterfly_pipe;
    localparam int N = 32;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset, recv_val, recv_rdy, bypass, scale, send_val, send_rdy, ovf;
    logic signed [N-1:0] ar, ac, br, bc, wr, wc, cr, cc, dr, dc;

    butterfly_pipe #(.N(N), .D(D), .STAGES(3)) dut (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
        .bypass(bypass), .scale(scale), .send_val(send_val), .send_rdy(send_rdy),
        .cr(cr), .cc(cc), .dr(dr), .dc(dc), .ovf(ovf)
    );

    typedef struct packed {
        logic [N-1:0] ar, ac, br, bc, wr, wc;
        logic         bypass, scale;
    } txn_t;

    typedef struct packed {
        logic [N-1:0] cr, cc, dr, dc;
        logic         ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_acc  = 0;

    localparam logic signed [127:0] MAXV = (128'sd1 <<< (N-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (N-1));

    // Reduce an exact integer to N bits: returns {overflowed, value}.
    function automatic logic [N:0] fit(input logic signed [127:0] v);
        logic signed [127:0] r;
        logic                o;
        r = v;
        o = 1'b0;
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (v > MAXV) begin
            r = MAXV;
            o = 1'b1;
        end else if (v < MINV) begin
            r = MINV;
            o = 1'b1;
        end
`endif
        return {o, r[N-1:0]};
    endfunction

    function automatic exp_t model(input txn_t t);
        logic signed [127:0] a_r, a_c, b_r, b_c, w_r, w_c, t_r, t_c, r;
        logic signed [127:0] s [4];
        logic [N-1:0]        vals [4];
        logic [N:0]          f;
        logic                o;
        exp_t                e;
        a_r = $signed(t.ar);
        a_c = $signed(t.ac);
        b_r = $signed(t.br);
        b_c = $signed(t.bc);
        w_r = $signed(t.wr);
        w_c = $signed(t.wc);
        o   = 1'b0;
        if (t.bypass) begin
            t_r = b_r;
            t_c = b_c;
        end else begin
            f   = fit((b_r * w_r - b_c * w_c) >>> D);
            o   = o | f[N];
            t_r = $signed(f[N-1:0]);
            f   = fit((b_r * w_c + b_c * w_r) >>> D);
            o   = o | f[N];
            t_c = $signed(f[N-1:0]);
        end
        s[0] = a_r + t_r;
        s[1] = a_c + t_c;
        s[2] = a_r - t_r;
        s[3] = a_c - t_c;
        for (int k = 0; k < 4; k++) begin
            if (t.scale) begin
                r       = s[k] >>> 1;
                vals[k] = r[N-1:0];
            end else begin
                f       = fit(s[k]);
                o       = o | f[N];
                vals[k] = f[N-1:0];
            end
        end
        e.cr  = vals[0];
        e.cc  = vals[1];
        e.dr  = vals[2];
        e.dc  = vals[3];
        e.ovf = o;
        return e;
    endfunction

    function automatic txn_t mk_txn(input logic [N-1:0] a_r, a_c, b_r, b_c, w_r, w_c,
                                    input logic byp, scl);
        txn_t t;
        t.ar = a_r; t.ac = a_c; t.br = b_r; t.bc = b_c; t.wr = w_r; t.wc = w_c;
        t.bypass = byp;
        t.scale  = scl;
        return t;
    endfunction

    function automatic exp_t mk_exp(input logic [N-1:0] c_r, c_c, d_r, d_c, input logic o);
        exp_t e;
        e.cr = c_r; e.cc = c_c; e.dr = d_r; e.dc = d_c; e.ovf = o;
        return e;
    endfunction

    function automatic logic [N-1:0] rnd(input bit full);
        logic [N-1:0] x;
        x = $urandom;
        if (full) return x;
        return {{(N-20){x[19]}}, x[19:0]};
    endfunction

    function automatic txn_t rand_txn();
        bit full;
        full = ($urandom_range(0, 3) == 0);
        return mk_txn(rnd(full), rnd(full), rnd(full), rnd(full), rnd(full), rnd(full),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    endfunction

    task automatic load(input txn_t t);
        ar = t.ar; ac = t.ac; br = t.br; bc = t.bc; wr = t.wr; wc = t.wc;
        bypass = t.bypass;
        scale  = t.scale;
    endtask

    // Present one transaction until it is accepted; push its expectation on acceptance.
    task automatic drive(input txn_t t, input exp_t e, input bit push);
        bit acc;
        int waitc;
        acc   = 1'b0;
        waitc = 0;
        load(t);
        recv_val = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = recv_rdy;
            @(posedge clk);
            #1;
            if (!acc) begin
                waitc++;
                if (waitc > 500) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: recv_rdy=%b after %0d cycles, required 1", recv_rdy, waitc);
                    break;
                end
            end
        end
        if (acc) begin
            if (push) exp_q.push_back(e);
            n_acc++;
        end
        recv_val = 1'b0;
    endtask

    // One transaction on an idle pipe, with the accept-to-valid latency checked.
    task automatic single(input string name, input txn_t t, input exp_t e);
        int lat;
        drive(t, e, 1'b1);
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (send_val || lat > 20) break;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL latency_%s: got %0d cycles, required 3", name, lat);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks held outputs during stalls.
    exp_t         mon_e;
    logic         stall_prev = 1'b0;
    logic [N-1:0] pcr, pcc, pdr, pdc;
    logic         povf;

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if ({cr, cc, dr, dc, ovf} !== {pcr, pcc, pdr, pdc, povf}) begin
                    errors++;
                    $display("FAIL hold_stable: got cr=%h cc=%h dr=%h dc=%h ovf=%b, required cr=%h cc=%h dr=%h dc=%h ovf=%b",
                             cr, cc, dr, dc, ovf, pcr, pcc, pdr, pdc, povf);
                end
            end
            if (send_val && send_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got cr=%h cc=%h dr=%h dc=%h with no transaction outstanding", cr, cc, dr, dc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({cr, cc, dr, dc, ovf} !== {mon_e.cr, mon_e.cc, mon_e.dr, mon_e.dc, mon_e.ovf}) begin
                        errors++;
                        $display("FAIL result: got cr=%h cc=%h dr=%h dc=%h ovf=%b, required cr=%h cc=%h dr=%h dc=%h ovf=%b",
                                 cr, cc, dr, dc, ovf, mon_e.cr, mon_e.cc, mon_e.dr, mon_e.dc, mon_e.ovf);
                    end
                end
            end
            stall_prev = send_val && !send_rdy;
            pcr = cr; pcc = cc; pdr = dr; pdc = dc; povf = ovf;
        end
    end

    txn_t tx;
    exp_t ex;
    int   base;
    bit   bp_done, rnd_done;

    initial begin
        reset = 1'b0; recv_val = 1'b0; send_rdy = 1'b1;
        ar = '0; ac = '0; br = '0; bc = '0; wr = '0; wc = '0; bypass = 1'b0; scale = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b1 || {cr, cc, dr, dc, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state: got send_val=%b recv_rdy=%b cr=%h cc=%h dr=%h dc=%h ovf=%b, required 0 1 and zero outputs",
                     send_val, recv_rdy, cr, cc, dr, dc, ovf);
        end
        @(posedge clk);
        #1;

        single("basic", mk_txn(32'h00010000, 0, 32'h00020000, 0, 0, 32'h00010000, 1'b0, 1'b0),
               mk_exp(32'h00010000, 32'h00020000, 32'h00010000, 32'hFFFE0000, 1'b0));
        single("bypass", mk_txn(0, 0, 32'h00008000, 32'h00004000, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0),
               mk_exp(32'h00008000, 32'h00004000, 32'hFFFF8000, 32'hFFFFC000, 1'b0));
        single("scale", mk_txn(32'h00030000, 0, 32'h00010000, 0, 32'h00010000, 0, 1'b0, 1'b1),
               mk_exp(32'h00020000, 0, 32'h00010000, 0, 1'b0));
`ifdef BUTTERFLY_PIPE_SAT_EN
        ex = mk_exp(32'h7FFFFFFF, 0, 32'h7FFD0000, 0, 1'b1);
`else
        ex = mk_exp(32'h80010000, 0, 32'h7FFD0000, 0, 1'b0);
`endif
        single("overflow", mk_txn(32'h7FFF0000, 0, 32'h00020000, 0, 32'h00010000, 0, 1'b0, 1'b0), ex);

        // Backpressure: eight back-to-back transactions, output blocked for ten cycles then toggled.
        base    = n_acc;
        bp_done = 1'b0;
        send_rdy = 1'b0;
        fork
            begin : bp_drv
                txn_t t;
                for (int i = 0; i < 8; i++) begin
                    t = rand_txn();
                    drive(t, model(t), 1'b1);
                end
                bp_done = 1'b1;
            end
            begin : bp_rdy
                int guard;
                repeat (10) @(posedge clk);
                #1;
                checks++;
                if (recv_rdy !== 1'b0 || n_acc - base != 3) begin
                    errors++;
                    $display("FAIL bp_fill: got recv_rdy=%b accepted=%0d, required recv_rdy=0 accepted=3", recv_rdy, n_acc - base);
                end
                guard = 0;
                while ((!bp_done || exp_q.size() != 0) && guard < 300) begin
                    send_rdy = ~send_rdy;
                    @(posedge clk);
                    #1;
                    guard++;
                end
                send_rdy = 1'b1;
            end
        join

        // Reset mid-flight: two in-flight transactions and one presented on the reset edge are all discarded.
        drive(mk_txn(32'h00050000, 32'h00010000, 32'h00010000, 0, 32'h00010000, 0, 1'b0, 1'b0), '0, 1'b0);
        drive(mk_txn(32'h00070000, 0, 32'h00020000, 0, 32'h00010000, 0, 1'b0, 1'b0), '0, 1'b0);
        reset = 1'b0;
        load(mk_txn(32'h00090000, 0, 32'h00030000, 0, 32'h00010000, 0, 1'b0, 1'b0));
        recv_val = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        recv_val = 1'b0;
        @(negedge clk);
        checks++;
        if (send_val !== 1'b0 || recv_rdy !== 1'b1 || {cr, cc, dr, dc, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_flush: got send_val=%b recv_rdy=%b cr=%h cc=%h dr=%h dc=%h ovf=%b, required 0 1 and zero outputs",
                     send_val, recv_rdy, cr, cc, dr, dc, ovf);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (send_val !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat: got send_val=%b cr=%h, required send_val=0", send_val, cr);
            end
        end
        @(posedge clk);
        #1;
        tx = mk_txn(32'hFFFF0000, 32'h00018000, 32'h00004000, 32'hFFFFC000, 32'h0000B505, 32'hFFFF4AFB, 1'b0, 1'b0);
        single("after_reset", tx, model(tx));

        // Randomized traffic with input gaps and random output backpressure.
        rnd_done = 1'b0;
        fork
            begin : r_drv
                txn_t t;
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                    t = rand_txn();
                    drive(t, model(t), 1'b1);
                end
                rnd_done = 1'b1;
            end
            begin : r_rdy
                int g;
                g = 0;
                while ((!rnd_done || exp_q.size() != 0) && g < 5000) begin
                    send_rdy = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                    g++;
                end
                send_rdy = 1'b1;
            end
        join

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
